// File: rtl/br_fifo_ext_arb_wrr_pkg.sv
// Shared helpers for the weighted round-robin external arbiter.
//   eff_weight    : clamps a raw weight to [1, max_w] (0 behaves as 1).
//   rot_first_one : rotating first-one search. It scans start+1, start+2, ...
//                   and wraps modulo n. The scan ends at start itself.
// Port-independent, so the formal bench can import it unchanged.
package br_fifo_ext_arb_wrr_pkg;

    // Upper bound on NumFifos supported by the rotating search.
    localparam int unsigned MaxFifos = 32;
    localparam int unsigned IdxWidth = $clog2(MaxFifos);

    typedef struct packed {
        logic                found;
        logic [IdxWidth-1:0] idx;
    } rot_sel_t;

    function automatic logic [31:0] eff_weight(input logic [31:0] w, input logic [31:0] max_w);
        if (w == 32'd0)  return 32'd1;
        if (w > max_w)   return max_w;
        return w;
    endfunction

    function automatic rot_sel_t rot_first_one(input logic [MaxFifos-1:0] mask,
                                               input int unsigned         n,
                                               input int unsigned         start);
        rot_sel_t    sel;
        int unsigned idx;
        sel = '0;
        for (int unsigned i = 0; i < MaxFifos; i++) begin
            // start < n and i < n, so a single subtraction wraps the index.
            idx = start + 1 + i;
            if (idx >= n) idx = idx - n;
            if ((i < n) && !sel.found && mask[idx[IdxWidth-1:0]]) begin
                sel.found = 1'b1;
                sel.idx   = idx[IdxWidth-1:0];
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/br_fifo_ext_arb_wrr_if.sv
// Arbiter interface between the external-arbitration FIFO and its arbiter.
//   arb_request                : [ports][fifos] request vectors (FIFO -> arb)
//   arb_enable_priority_update : [ports] commit the current grant (FIFO -> arb)
//   fifo_weight                : [fifos] burst weights, shared by all ports
//   arb_grant                  : [ports][fifos] one-hot grants (arb -> FIFO)
// master = FIFO side, slave = arbiter side.
interface br_fifo_ext_arb_wrr_if #(
    parameter int unsigned NumReadPorts = 1,
    parameter int unsigned NumFifos     = 2,
    parameter int unsigned MaxWeight    = 4,
    parameter int unsigned WeightWidth  = $clog2(MaxWeight + 1)
);
    logic [NumReadPorts-1:0][NumFifos-1:0]    arb_request;
    logic [NumReadPorts-1:0]                  arb_enable_priority_update;
    logic [NumFifos-1:0][WeightWidth-1:0]     fifo_weight;
    logic [NumReadPorts-1:0][NumFifos-1:0]    arb_grant;

    modport master (
        output arb_request,
        output arb_enable_priority_update,
        output fifo_weight,
        input  arb_grant
    );

    modport slave (
        input  arb_request,
        input  arb_enable_priority_update,
        input  fifo_weight,
        output arb_grant
    );
endinterface

// File: rtl/br_fifo_ext_arb_wrr_port.sv
// Single-port weighted round-robin arbiter.
//   clk, rst  : clock, synchronous active-high reset
//   req_i     : FIFO request vector for this port
//   upd_i     : commit the current grant into holder/burst state
//   weight_i  : raw per-FIFO weights (0 -> 1, clamped to MaxWeight)
//   grant_o   : combinational onehot0 grant, always a subset of req_i
module br_fifo_ext_arb_wrr_port
    import br_fifo_ext_arb_wrr_pkg::*;
#(
    parameter int unsigned NumFifos    = 2,
    parameter int unsigned MaxWeight   = 4,
    parameter int unsigned WeightWidth = $clog2(MaxWeight + 1)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NumFifos-1:0]               req_i,
    input  logic                              upd_i,
    input  logic [NumFifos-1:0][WeightWidth-1:0] weight_i,
    output logic [NumFifos-1:0]               grant_o
);
    localparam int unsigned HolderWidth = $clog2(NumFifos);

    logic [HolderWidth-1:0] holder_q, holder_d;
    logic [WeightWidth-1:0] burst_cnt_q, burst_cnt_d;

    logic [WeightWidth-1:0] hold_weight;
    logic                   cont;
    rot_sel_t               sel;
    logic                   gnt_vld;
    logic [HolderWidth-1:0] gnt_idx;

    // Grant path. A burst count of 0 exists only out of reset. It means no
    // burst is in progress, so the reset holder (NumFifos-1) does not win
    // outright, and FIFO 0 gets top priority.
    always_comb begin
        hold_weight = WeightWidth'(eff_weight(32'(weight_i[holder_q]), 32'(MaxWeight)));
        cont        = req_i[holder_q] && (burst_cnt_q != '0) && (burst_cnt_q < hold_weight);
        sel         = rot_first_one(MaxFifos'(req_i), NumFifos, 32'(holder_q));
        gnt_vld     = cont || sel.found;
        gnt_idx     = cont ? holder_q : HolderWidth'(sel.idx);
        grant_o     = '0;
        if (gnt_vld) grant_o[gnt_idx] = 1'b1;
    end

    // Priority state moves only on an enabled update that actually granted.
    always_comb begin
        holder_d    = holder_q;
        burst_cnt_d = burst_cnt_q;
        if (upd_i && gnt_vld) begin
            if (gnt_idx == holder_q) begin
                if (32'(burst_cnt_q) < MaxWeight) burst_cnt_d = burst_cnt_q + WeightWidth'(1);
            end else begin
                holder_d    = gnt_idx;
                burst_cnt_d = WeightWidth'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            holder_q    <= HolderWidth'(NumFifos - 1);
            burst_cnt_q <= '0;
        end else begin
            holder_q    <= holder_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

endmodule

// File: rtl/br_fifo_ext_arb_wrr.sv
// External weighted round-robin arbiter for br_fifo_ext_arb. Each read port
// has its own independent arbiter. The weights are fanned out to all ports.
//   clk, rst : clock, synchronous active-high reset
//   arb_if   : slave side of the arbiter interface (requests, priority
//              update enables and weights in; same-cycle grants out)
module br_fifo_ext_arb_wrr #(
    parameter int unsigned NumReadPorts = 1,
    parameter int unsigned NumFifos     = 2,
    parameter int unsigned MaxWeight    = 4,
    parameter int unsigned WeightWidth  = $clog2(MaxWeight + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    br_fifo_ext_arb_wrr_if.slave  arb_if
);
    logic [NumReadPorts-1:0][NumFifos-1:0] grant;

    for (genvar r = 0; r < NumReadPorts; r++) begin : g_port
        br_fifo_ext_arb_wrr_port #(
            .NumFifos    (NumFifos),
            .MaxWeight   (MaxWeight),
            .WeightWidth (WeightWidth)
        ) u_port (
            .clk      (clk),
            .rst      (rst),
            .req_i    (arb_if.arb_request[r]),
            .upd_i    (arb_if.arb_enable_priority_update[r]),
            .weight_i (arb_if.fifo_weight),
            .grant_o  (grant[r])
        );
    end

    assign arb_if.arb_grant = grant;

endmodule
